// File: rtl/axi4_stream_arb_pkg.sv
// Shared types for the packet-granular AXI4-Stream arbiter.
// Holds the FSM state encoding and the watchdog default.
package axi4_stream_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int WDT_CYCLES_DEF = 256;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
// Strobe/keep widths follow tdata in whole bytes.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    localparam int TSTRB_WIDTH = (TDATA_WIDTH + 7) / 8;

    logic [TDATA_WIDTH-1:0] tdata;
    logic [TSTRB_WIDTH-1:0] tstrb;
    logic [TSTRB_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TID_WIDTH-1:0]   tid;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tdata, tstrb, tkeep, tlast,
        output tuser, tdest, tid, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tlast,
        input  tuser, tdest, tid, tvalid,
        output tready
    );

endinterface

// File: rtl/axi4_stream_pkt_arbiter_rr_select.sv
// Combinational round-robin selector: first request strictly
// after last_idx, found by rotating a doubled request vector.
module rr_select #(
    parameter int N         = 4,
    parameter int SEL_WIDTH = $clog2(N)
) (
    input  logic [N-1:0]         req,
    input  logic [SEL_WIDTH-1:0] last_idx,
    output logic                 any_o,
    output logic [SEL_WIDTH-1:0] winner
);
    logic [N-1:0] rot;
    int           start;
    int           off;
    int           sum;

    // rotate so bit 0 is the slot after last_idx, then take lowest set bit
    always_comb begin
        start = int'(last_idx) + 1;
        rot   = N'({req, req} >> start);
        off   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
        sum = start + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = SEL_WIDTH'(sum);
        any_o  = |req;
    end

endmodule

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter for AXI4-Stream sources.
// Optional stall watchdog: AXI4_STREAM_PKT_ARBITER_WATCHDOG_EN.
module axi4_stream_pkt_arbiter
    import axi4_stream_arb_pkg::*;
#(
    parameter int N_INPUTS    = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int PKT_GATE    = 1,
    parameter int SEL_WIDTH   = $clog2(N_INPUTS)
`ifdef AXI4_STREAM_PKT_ARBITER_WATCHDOG_EN
    ,
    parameter int WDT_CYCLES  = WDT_CYCLES_DEF
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_INPUTS-1:0]  pkt_avail_i,
    output logic [N_INPUTS-1:0]  grant_o,
    output logic [SEL_WIDTH-1:0] grant_idx_o,
    output logic                 busy_o,
`ifdef AXI4_STREAM_PKT_ARBITER_WATCHDOG_EN
    output logic                 wdt_expired_o,
`endif
    axi4_stream_if.slave         pkt_i [N_INPUTS],
    axi4_stream_if.master        pkt_o
);
    localparam int KW = (TDATA_WIDTH + 7) / 8;

    logic [TDATA_WIDTH-1:0] in_tdata [N_INPUTS];
    logic [KW-1:0]          in_tstrb [N_INPUTS];
    logic [KW-1:0]          in_tkeep [N_INPUTS];
    logic [TUSER_WIDTH-1:0] in_tuser [N_INPUTS];
    logic [TDEST_WIDTH-1:0] in_tdest [N_INPUTS];
    logic [TID_WIDTH-1:0]   in_tid   [N_INPUTS];
    logic [N_INPUTS-1:0]    in_tvalid;
    logic [N_INPUTS-1:0]    in_tlast;
    logic [N_INPUTS-1:0]    in_tready;
    logic [N_INPUTS-1:0]    elig;

    logic [TDATA_WIDTH-1:0] o_tdata;
    logic [KW-1:0]          o_tstrb;
    logic [KW-1:0]          o_tkeep;
    logic [TUSER_WIDTH-1:0] o_tuser;
    logic [TDEST_WIDTH-1:0] o_tdest;
    logic [TID_WIDTH-1:0]   o_tid;
    logic                   o_tlast;
    logic                   o_tvalid;

    arb_state_e             state_q, state_n;
    logic [SEL_WIDTH-1:0]   grant_idx_q, grant_idx_n;
    logic [SEL_WIDTH-1:0]   last_idx_q, last_idx_n;
    logic                   any_req;
    logic [SEL_WIDTH-1:0]   winner;
    logic                   pkt_done;
    logic                   wdt_fire;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_src
        assign in_tdata[g]     = pkt_i[g].tdata;
        assign in_tstrb[g]     = pkt_i[g].tstrb;
        assign in_tkeep[g]     = pkt_i[g].tkeep;
        assign in_tuser[g]     = pkt_i[g].tuser;
        assign in_tdest[g]     = pkt_i[g].tdest;
        assign in_tid[g]       = pkt_i[g].tid;
        assign in_tlast[g]     = pkt_i[g].tlast;
        assign in_tvalid[g]    = pkt_i[g].tvalid;
        assign pkt_i[g].tready = in_tready[g];
        assign elig[g]         = pkt_i[g].tvalid &
                                 ((PKT_GATE != 0) ? pkt_avail_i[g] : 1'b1);
    end

    rr_select #(
        .N         (N_INPUTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr (
        .req      (elig),
        .last_idx (last_idx_q),
        .any_o    (any_req),
        .winner   (winner)
    );

    // route the granted source to the output; everything quiet when idle
    always_comb begin
        o_tdata   = '0;
        o_tstrb   = '0;
        o_tkeep   = '0;
        o_tuser   = '0;
        o_tdest   = '0;
        o_tid     = '0;
        o_tlast   = 1'b0;
        o_tvalid  = 1'b0;
        in_tready = '0;
        if (state_q == XFER) begin
            o_tdata   = in_tdata[grant_idx_q];
            o_tstrb   = in_tstrb[grant_idx_q];
            o_tkeep   = in_tkeep[grant_idx_q];
            o_tuser   = in_tuser[grant_idx_q];
            o_tdest   = in_tdest[grant_idx_q];
            o_tid     = in_tid[grant_idx_q];
            o_tlast   = in_tlast[grant_idx_q];
            o_tvalid  = in_tvalid[grant_idx_q];
            in_tready[grant_idx_q] = pkt_o.tready;
        end
    end

    assign pkt_o.tdata  = o_tdata;
    assign pkt_o.tstrb  = o_tstrb;
    assign pkt_o.tkeep  = o_tkeep;
    assign pkt_o.tuser  = o_tuser;
    assign pkt_o.tdest  = o_tdest;
    assign pkt_o.tid    = o_tid;
    assign pkt_o.tlast  = o_tlast;
    assign pkt_o.tvalid = o_tvalid;

    assign pkt_done = o_tvalid & pkt_o.tready & o_tlast;

`ifdef AXI4_STREAM_PKT_ARBITER_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt_q;

    assign wdt_fire = (state_q == XFER) & ~o_tvalid &
                      (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));
    assign wdt_expired_o = wdt_fire;

    // count consecutive stalled cycles of the granted source
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdt_cnt_q <= '0;
        end else if ((state_q != XFER) || o_tvalid || wdt_fire) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_q + 1'b1;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    // arbitration state and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= SEL_WIDTH'(N_INPUTS - 1);
        end else begin
            state_q     <= state_n;
            grant_idx_q <= grant_idx_n;
            last_idx_q  <= last_idx_n;
        end
    end

    // grant only at packet boundaries, release on tlast or watchdog
    always_comb begin
        state_n     = state_q;
        grant_idx_n = grant_idx_q;
        last_idx_n  = last_idx_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_idx_n = winner;
                    state_n     = XFER;
                end
            end
            XFER: begin
                if (pkt_done || wdt_fire) begin
                    last_idx_n = grant_idx_q;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_o      = (state_q == XFER);
    assign grant_idx_o = grant_idx_q;
    assign grant_o     = busy_o ? (N_INPUTS'(1) << grant_idx_q) : '0;

endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Directed bench for axi4_stream_pkt_arbiter (N=4, PKT_GATE=1).
// Sources are modelled as simple packet queues with optional gaps.
module tb_axi4_stream_pkt_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] avail = '0;
    logic [N-1:0] grant;
    logic [1:0]   gidx;
    logic         busy;
    logic         o_ready = 1'b1;
`ifdef AXI4_STREAM_PKT_ARBITER_WATCHDOG_EN
    logic         wdt;
`endif

    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(32)) src [N] ();
    axi4_stream_if #(.TDATA_WIDTH(32)) snk ();

    logic [31:0]  s_tdata [N];
    logic [N-1:0] s_tvalid = '0;
    logic [N-1:0] s_tlast = '0;
    logic [N-1:0] s_tready;

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign src[g].tdata  = s_tdata[g];
        assign src[g].tstrb  = 4'hF;
        assign src[g].tkeep  = 4'hF;
        assign src[g].tuser  = ((g % 2) == 1);
        assign src[g].tdest  = (((g / 2) % 2) == 1);
        assign src[g].tid    = ((g % 2) == 0);
        assign src[g].tlast  = s_tlast[g];
        assign src[g].tvalid = s_tvalid[g];
        assign s_tready[g]   = src[g].tready;
    end

    assign snk.tready = o_ready;

    axi4_stream_pkt_arbiter #(
        .N_INPUTS    (N),
        .TDATA_WIDTH (32),
        .PKT_GATE    (1)
`ifdef AXI4_STREAM_PKT_ARBITER_WATCHDOG_EN
        ,
        .WDT_CYCLES  (8)
`endif
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pkt_avail_i   (avail),
        .grant_o       (grant),
        .grant_idx_o   (gidx),
        .busy_o        (busy),
`ifdef AXI4_STREAM_PKT_ARBITER_WATCHDOG_EN
        .wdt_expired_o (wdt),
`endif
        .pkt_i         (src),
        .pkt_o         (snk)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          npk   [N];
    int          len   [N];
    int          beat  [N];
    int          pnum  [N];
    logic [3:0]  gap   [N];
    logic        hold  [N];
    logic        stall [N];
    logic [63:0] log_q [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] eb(input int s, input int p,
                                       input int b);
        logic [1:0] sv;
        sv = 2'(s);
        return {21'b0, 4'hF, 4'hF, sv[0], sv[1], ~sv[0],
                8'(s), 8'(p), 16'(b)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = (npk[i] > 0) && !hold[i] && !stall[i];
            s_tlast[i]  = (beat[i] == len[i] - 1);
            s_tdata[i]  = {8'(i), 8'(pnum[i]), 16'(beat[i])};
        end
    endtask

    task automatic step();
        logic [N-1:0] hs;
        logic         ohs;
        logic [63:0]  ob;
        hs  = s_tvalid & s_tready;
        ohs = snk.tvalid && o_ready;
        ob  = {21'b0, snk.tkeep, snk.tstrb, snk.tuser, snk.tdest,
               snk.tid, snk.tdata};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hold[i]) begin
                hold[i] = 1'b0;
            end else if (hs[i]) begin
                if (gap[i][beat[i][1:0]]) hold[i] = 1'b1;
                beat[i]++;
                if (beat[i] == len[i]) begin
                    beat[i] = 0;
                    pnum[i]++;
                    npk[i]--;
                end
            end
        end
        if (ohs) log_q.push_back(ob);
        drive();
        #1;
    endtask

    task automatic chk_log(input string tag, input int idx, input int s,
                           input int p, input int b);
        chk($sformatf("%s[%0d]", tag, idx), log_q[idx], eb(s, p, b));
    endtask

    logic [3:0] t1g [16];
    logic [3:0] t3g [9];
    logic       t3v [9];

    initial begin
        t1g = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd2, 4'd0,
                4'd4, 4'd4, 4'd4, 4'd0, 4'd8, 4'd8, 4'd8, 4'd0};
        t3g = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd1, 4'd0};
        t3v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < N; i++) begin
            npk[i] = 0; len[i] = 1; beat[i] = 0; pnum[i] = 0;
            gap[i] = '0; hold[i] = 1'b0; stall[i] = 1'b0;
        end
        drive();

        // reset state
        #12;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_idx", 64'(gidx), 64'h0);
        chk("rst_valid", 64'(snk.tvalid), 64'h0);
        chk("rst_ready", 64'(s_tready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // all four sources, one 3-beat packet each
        avail = 4'hF;
        for (int i = 0; i < N; i++) begin
            npk[i] = 1; len[i] = 3;
        end
        drive();
        #1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("t1_grant[%0d]", k), 64'(grant), 64'(t1g[k]));
            chk($sformatf("t1_rdy[%0d]", k), 64'(s_tready), 64'(t1g[k]));
            chk($sformatf("t1_vld[%0d]", k), 64'(snk.tvalid),
                64'(t1g[k] != 0));
            if (t1g[k] != 0)
                chk($sformatf("t1_idx[%0d]", k), 64'(gidx), 64'(k / 4));
        end
        chk("t1_len", 64'(log_q.size()), 64'd12);
        for (int k = 0; k < 12; k++) chk_log("t1_beat", k, k / 3, 0, k % 3);

        // packet gating: src2 valid but not available
        log_q.delete();
        avail = 4'b1000;
        npk[2] = 1; len[2] = 1;
        npk[3] = 1; len[3] = 1;
        drive();
        #1;
        step(); chk("t2_g0", 64'(grant), 64'h8);
        step(); chk("t2_g1", 64'(grant), 64'h0);
        step(); chk("t2_g2", 64'(grant), 64'h0);
        step(); chk("t2_g3", 64'(grant), 64'h0);
        avail = 4'b1100;
        #1;
        step(); chk("t2_g4", 64'(grant), 64'h4);
        step(); chk("t2_g5", 64'(grant), 64'h0);
        chk("t2_len", 64'(log_q.size()), 64'd2);
        chk_log("t2_beat", 0, 3, 1, 0);
        chk_log("t2_beat", 1, 2, 1, 0);

        // src1 4-beat packet with gaps; src0 joins while src1 holds grant
        log_q.delete();
        avail = 4'hF;
        npk[1] = 1; len[1] = 4; gap[1] = 4'b0101;
        drive();
        #1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 0) begin
                npk[0] = 1; len[0] = 1;
                drive();
                #1;
            end
            chk($sformatf("t3_grant[%0d]", k), 64'(grant), 64'(t3g[k]));
            chk($sformatf("t3_vld[%0d]", k), 64'(snk.tvalid), 64'(t3v[k]));
        end
        gap[1] = '0;
        chk("t3_len", 64'(log_q.size()), 64'd5);
        for (int k = 0; k < 4; k++) chk_log("t3_beat", k, 1, 1, k);
        chk_log("t3_beat", 4, 0, 1, 0);

        // tready 1-0-1 during a 2-beat packet from src2
        log_q.delete();
        npk[2] = 1; len[2] = 2;
        drive();
        #1;
        step(); chk("t4_g0", 64'(grant), 64'h4);
        chk("t4_rdy0", 64'(s_tready), 64'h4);
        step(); chk("t4_g1", 64'(grant), 64'h4);
        o_ready = 1'b0;
        #1;
        chk("t4_rdy_lo", 64'(s_tready), 64'h0);
        step(); chk("t4_g2", 64'(grant), 64'h4);
        chk("t4_vld2", 64'(snk.tvalid), 64'h1);
        o_ready = 1'b1;
        #1;
        step(); chk("t4_g3", 64'(grant), 64'h0);
        chk("t4_len", 64'(log_q.size()), 64'd2);
        chk_log("t4_beat", 0, 2, 2, 0);
        chk_log("t4_beat", 1, 2, 2, 1);

        // reset after two beats of a src3 packet
        npk[3] = 1; len[3] = 3;
        drive();
        #1;
        step(); chk("t5_g0", 64'(grant), 64'h8);
        step();
        step();
        chk("t5_busy_pre", 64'(busy), 64'h1);
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_grant", 64'(grant), 64'h0);
        chk("t5_vld", 64'(snk.tvalid), 64'h0);
        chk("t5_rdy", 64'(s_tready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        npk[0] = 1; len[0] = 1;
        drive();
        #1;
        step(); chk("t5_g1", 64'(grant), 64'h1);
        step(); chk("t5_g2", 64'(grant), 64'h0);
        step(); chk("t5_g3", 64'(grant), 64'h8);
        step(); chk("t5_g4", 64'(grant), 64'h0);
        chk("t5_len", 64'(log_q.size()), 64'd2);
        chk_log("t5_beat", 0, 0, 2, 0);
        chk_log("t5_beat", 1, 3, 2, 2);

`ifdef AXI4_STREAM_PKT_ARBITER_WATCHDOG_EN
        // src1 stalls mid-packet; watchdog releases the grant
        npk[1] = 1; len[1] = 2;
        drive();
        #1;
        step(); chk("t6_g0", 64'(grant), 64'h2);
        step();
        stall[1] = 1'b1;
        npk[2] = 1; len[2] = 1;
        drive();
        #1;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("t6_wdt[%0d]", k), 64'(wdt), 64'h0);
            step();
        end
        chk("t6_wdt_hit", 64'(wdt), 64'h1);
        chk("t6_g_hit", 64'(grant), 64'h2);
        step(); chk("t6_wdt_off", 64'(wdt), 64'h0);
        chk("t6_g_idle", 64'(grant), 64'h0);
        step(); chk("t6_g_next", 64'(grant), 64'h4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
